// File: rtl/sa_pkg.sv
// sa_pkg: shared defaults, feeder state encoding and counter sizing for the systolic-array feeder
package sa_pkg;
  localparam int ROWS_DEF = 4;
  localparam int DATA_W_DEF = 16;
  localparam int MAX_LEN_DEF = 32;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  function automatic int pass_cnt_w(input int rows, input int max_len);
    return $clog2(max_len + rows + 4);
  endfunction
endpackage

// File: rtl/skew_lane.sv
// skew_lane: one row's diagonal read schedule (t in [IDX, IDX+len-1]) and two-stage zero-padded output
// ports: CLK/RST clock and sync reset; feed high while the pass is in FEED; t pass counter; len
// latched elements per row; empty/dout this row's FIFO flag and data; rd read strobe; under
// scheduled slot hit an empty FIFO; a_out/a_valid skewed operand to the array.
module skew_lane #(
  parameter int IDX = 0,
  parameter int DATA_W = 16,
  parameter int TW = 6,
  parameter int LW = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              feed,
  input  logic [TW-1:0]     t,
  input  logic [LW-1:0]     len,
  input  logic              empty,
  input  logic [DATA_W-1:0] dout,
  output logic              rd,
  output logic              under,
  output logic [DATA_W-1:0] a_out,
  output logic              a_valid
);
  logic sched;
  logic pend;
  assign sched = feed && t >= TW'(IDX) && (t - TW'(IDX)) < TW'(len);
  assign rd = sched && !empty;
  assign under = sched && empty;
  // pend marks the cycle the FIFO presents the element read one cycle earlier
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend <= 1'b0;
      a_valid <= 1'b0;
      a_out <= '0;
    end else begin
      pend <= rd;
      a_valid <= pend;
      a_out <= pend ? dout : '0;
    end
  end
endmodule

// File: rtl/row_skew_feeder.sv
// row_skew_feeder: drains ROWS hFIFOs into the west edge of a systolic array with one-cycle-per-row skew
// ports: CLK/RST clock and sync active-high reset; start/len pass request and elements per row;
// fifo_dout/fifo_empty per-row FIFO data and empty flag; fifo_rd per-row read strobe;
// a_out/a_valid skewed operands; busy in FEED/DRAIN; done one-cycle end pulse; err sticky underflow.
module row_skew_feeder
  import sa_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [$clog2(MAX_LEN+1)-1:0] len,
  input  logic [ROWS*DATA_W-1:0]   fifo_dout,
  input  logic [ROWS-1:0]          fifo_empty,
  output logic [ROWS-1:0]          fifo_rd,
  output logic [ROWS*DATA_W-1:0]   a_out,
  output logic [ROWS-1:0]          a_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = pass_cnt_w(ROWS, MAX_LEN);
  state_t state, state_n;
  logic [TW-1:0] t;
  logic [TW-1:0] feed_cycles;
  logic [LW-1:0] len_r;
  logic [ROWS-1:0] under;
  logic err_r;
  logic go;
  logic feed;
  assign go = start && len != '0 && len <= LW'(MAX_LEN);
  assign feed = state == FEED;
  assign feed_cycles = TW'(len_r) + TW'(ROWS - 1);
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = go ? FEED : IDLE;
      FEED:  state_n = (t == feed_cycles - TW'(1)) ? DRAIN : FEED;
      DRAIN: state_n = (t == feed_cycles + TW'(1)) ? DONE : DRAIN;
      DONE:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      t <= '0;
      len_r <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_n;
      t <= (state == IDLE) ? '0 : t + TW'(1);
      if (state == IDLE && go) begin
        len_r <= len;
        err_r <= 1'b0;
      end else if (|under) begin
        err_r <= 1'b1;
      end
    end
  end
  // the underflow term makes err visible in the very cycle the empty slot is skipped
  assign err = err_r | (|under);
  assign busy = state == FEED || state == DRAIN;
  assign done = state == DONE;
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    skew_lane #(.IDX(r), .DATA_W(DATA_W), .TW(TW), .LW(LW)) u_lane (
      .CLK(CLK),
      .RST(RST),
      .feed(feed),
      .t(t),
      .len(len_r),
      .empty(fifo_empty[r]),
      .dout(fifo_dout[r*DATA_W +: DATA_W]),
      .rd(fifo_rd[r]),
      .under(under[r]),
      .a_out(a_out[r*DATA_W +: DATA_W]),
      .a_valid(a_valid[r])
    );
  end
endmodule

// File: tb/tb_row_skew_feeder.sv
// tb_row_skew_feeder: FIFO environment plus slot-rule reference model for row_skew_feeder
module tb_row_skew_feeder;
  localparam int ROWS = 4;
  localparam int DW = 16;
  localparam int ML = 32;
  localparam int LW = $clog2(ML + 1);
  logic CLK = 0;
  logic RST = 1;
  logic start = 0;
  logic [LW-1:0] len = '0;
  logic [ROWS*DW-1:0] fifo_dout;
  logic [ROWS-1:0] fifo_empty;
  logic [ROWS-1:0] fifo_rd;
  logic [ROWS*DW-1:0] a_out;
  logic [ROWS-1:0] a_valid;
  logic busy, done, err;
  int checks = 0;
  int errors = 0;
  bit err_g = 0;
  logic [DW-1:0] mem [ROWS][4096];
  int head [ROWS];
  int tail [ROWS];
  logic [DW-1:0] dq [ROWS];

  row_skew_feeder #(.ROWS(ROWS), .DATA_W(DW), .MAX_LEN(ML)) dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .a_out(a_out), .a_valid(a_valid),
    .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK)
    for (int r = 0; r < ROWS; r++)
      if (fifo_rd[r]) begin
        dq[r] <= mem[r][head[r] % 4096];
        head[r] <= head[r] + 1;
      end

  always_comb
    for (int r = 0; r < ROWS; r++) begin
      fifo_empty[r] = head[r] >= tail[r];
      fifo_dout[r*DW +: DW] = dq[r];
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [DW-1:0] v);
    mem[r][tail[r] % 4096] = v;
    tail[r]++;
  endtask

  task automatic load_rand(input int r, input int n);
    for (int i = 0; i < n; i++) push(r, DW'($urandom));
  endtask

  task automatic chk_quiet(input string tag, input bit e);
    chk({tag, "_rd"}, fifo_rd, 0);
    chk({tag, "_valid"}, a_valid, 0);
    chk({tag, "_aout"}, a_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, e);
  endtask

  // expectations follow from the slot rules: row r owns slots t=r..r+len-1, a slot with data
  // shows up two cycles later, the first empty slot raises err, FEED+DRAIN spans len+ROWS+1 cycles
  task automatic run_pass(input int L, input int rst_at, input bit glitch);
    int n [ROWS];
    int h0 [ROWS];
    int cnt [ROWS];
    int first_under;
    int last;
    int eff;
    int k;
    logic [ROWS-1:0] e_rd, e_v;
    logic [ROWS*DW-1:0] e_out;
    first_under = 1 << 30;
    for (int r = 0; r < ROWS; r++) begin
      h0[r] = head[r];
      n[r] = tail[r] - head[r];
      cnt[r] = 0;
      if (n[r] < L && r + n[r] < first_under) first_under = r + n[r];
    end
    last = L + ROWS + 2;
    len = LW'(L);
    start = 1;
    @(posedge CLK);
    #1;
    start = 0;
    len = LW'($urandom);
    for (int tt = 0; tt <= last; tt++) begin
      for (int r = 0; r < ROWS; r++) begin
        eff = n[r] < L ? n[r] : L;
        k = tt - 2 - r;
        e_rd[r] = tt >= r && tt < r + eff;
        e_v[r] = k >= 0 && k < eff;
        e_out[r*DW +: DW] = e_v[r] ? mem[r][(h0[r] + k) % 4096] : '0;
        if (a_valid[r]) cnt[r]++;
      end
      chk($sformatf("rd_t%0d", tt), fifo_rd, e_rd);
      chk($sformatf("valid_t%0d", tt), a_valid, e_v);
      chk($sformatf("aout_t%0d", tt), a_out, e_out);
      chk($sformatf("busy_t%0d", tt), busy, tt <= L + ROWS);
      chk($sformatf("done_t%0d", tt), done, tt == L + ROWS + 1);
      chk($sformatf("err_t%0d", tt), err, tt >= first_under);
      start = glitch && tt == 2;
      if (tt == rst_at) begin
        RST = 1;
        @(posedge CLK);
        #1;
        RST = 0;
        err_g = 0;
        chk_quiet("midrst", 0);
        return;
      end
      @(posedge CLK);
      #1;
    end
    for (int r = 0; r < ROWS; r++) begin
      eff = n[r] < L ? n[r] : L;
      chk($sformatf("vcount_r%0d", r), cnt[r], eff);
    end
    err_g = last >= first_under;
  endtask

  initial begin
    for (int r = 0; r < ROWS; r++) begin
      head[r] = 0;
      tail[r] = 0;
    end
    repeat (3) @(posedge CLK);
    #1;
    chk_quiet("reset", 0);
    start = 1;
    len = LW'(4);
    @(posedge CLK);
    #1;
    start = 0;
    chk("rst_prio_busy", busy, 0);
    RST = 0;
    @(posedge CLK);
    #1;
    chk_quiet("after_rst", 0);

    for (int r = 0; r < ROWS; r++)
      for (int v = 1; v <= 4; v++) push(r, DW'(v));
    run_pass(4, -1, 0);

    for (int r = 0; r < ROWS; r++) load_rand(r, 32);
    run_pass(32, -1, 0);
    chk("full_drained", fifo_empty, {ROWS{1'b1}});

    load_rand(0, 4);
    load_rand(1, 4);
    load_rand(2, 2);
    load_rand(3, 4);
    run_pass(4, -1, 0);

    for (int r = 0; r < ROWS; r++) load_rand(r, 4);
    len = '0;
    start = 1;
    @(posedge CLK);
    #1;
    len = LW'(33);
    @(posedge CLK);
    #1;
    start = 0;
    repeat (2) begin
      chk_quiet("bad_len", err_g);
      @(posedge CLK);
      #1;
    end
    run_pass(4, -1, 1);

    for (int r = 0; r < ROWS; r++) load_rand(r, 8);
    run_pass(8, 3, 0);
    for (int r = 0; r < ROWS; r++) load_rand(r, 4);
    run_pass(8, -1, 0);

    repeat (6) begin
      int l;
      l = $urandom_range(1, ML);
      for (int r = 0; r < ROWS; r++)
        load_rand(r, ($urandom_range(0, 3) == 0) ? $urandom_range(0, l) : l);
      run_pass(l, -1, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/row_skew_feeder.md
ROW_SKEW_FEEDER -- requirements
Module: row_skew_feeder

Interface
REQ-001 SHALL have parameter ROWS, default 4: number of hFIFO rows drained (west edge of systolic array).
REQ-002 SHALL have parameter DATA_W, default 16: element width, equal to the hFIFO data width.
REQ-003 SHALL have parameter MAX_LEN, default 32: maximum elements per row, equal to the hFIFO depth.
REQ-004 CLK  input  1  the one clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset; synchronous and active-high.
REQ-006 start  input  1  one-cycle request to begin a feed pass; sampled only in IDLE.
REQ-007 len  input  $clog2(MAX_LEN+1)  elements per row; latched on accepted start.
REQ-008 fifo_dout  input  ROWS*DATA_W  per-row hFIFO data_o; valid the cycle after its read strobe.
REQ-009 fifo_empty  input  ROWS  per-row hFIFO E flag.
REQ-010 fifo_rd  output  ROWS  per-row read strobe (drives hFIFO EN with W=0).
REQ-011 a_out  output  ROWS*DATA_W  skewed operand to array row r.
REQ-012 a_valid  output  ROWS  a_out[r] holds a real element.
REQ-013 busy  output  1  high in FEED and DRAIN.
REQ-014 done  output  1  one-cycle pulse at end of pass.
REQ-015 err  output  1  sticky underflow flag; cleared by reset or accepted start.

Function
REQ-016 SHALL implement states IDLE, FEED, DRAIN, DONE; IDLE->FEED on start with len in 1..MAX_LEN; FEED->DRAIN after last scheduled read; DRAIN->DONE after 2 cycles; DONE->IDLE after 1 cycle.
REQ-017 start with len=0 or len>MAX_LEN SHALL be ignored (stay IDLE, err unchanged); start outside IDLE SHALL be ignored.
REQ-018 SHALL keep pass counter t, 0 in first FEED cycle, +1 per cycle; FEED lasts exactly len+ROWS-1 cycles.
REQ-019 Row r SHALL be scheduled to read for t in [r, r+len-1] (diagonal skew of one cycle per row).
REQ-020 fifo_rd[r] SHALL equal scheduled[r] AND NOT fifo_empty[r]; never asserted outside FEED.
REQ-021 Scheduled read with fifo_empty[r]=1 SHALL set err; slot is not retried, skew is preserved.
REQ-022 a_out[r]/a_valid[r] SHALL be registered: read at cycle t -> a_valid[r]=1 and a_out[r]=fifo_dout[r] at cycle t+2.
REQ-023 When a_valid[r]=0, a_out[r] SHALL be zero (zero padding into the array).
REQ-024 done SHALL be 1 only in DONE; busy SHALL be 1 only in FEED and DRAIN.
REQ-025 len SHALL be held in a register for the whole pass; input changes after start have no effect.

Reset
REQ-026 RST=1 at a clock edge SHALL force IDLE, t=0, fifo_rd=0, a_valid=0, a_out=0, busy=0, done=0, err=0, from any state including mid-FEED.
REQ-027 RST SHALL take priority over start in the same cycle.

Structure
REQ-028 DATA_W, ROWS, MAX_LEN defaults and the state enum SHALL live in shared package sa_pkg.
REQ-029 Per-row scheduling compare and two-stage output register SHALL be one sub-module skew_lane, instantiated ROWS times.

Verification
REQ-030 ROWS=4, len=4, FIFOs preloaded 1..4 per row: start -> row r a_valid at t=r+2..r+5 with values 1,2,3,4; done at t=9; err=0.
REQ-031 len=32, all FIFOs full -> 35 FEED cycles, each FIFO reaches E=1 after last read, err=0, exactly 32 valid outputs per row.
REQ-032 Row 2 preloaded with only 2 elements, len=4 -> err=1 at t=4, row 2 a_valid at t=4,5 only, a_out[2]=0 afterwards; other rows unaffected.
REQ-033 RST asserted at t=3 of a len=8 pass -> next cycle all outputs 0, state IDLE; a new start then runs a correct pass.
REQ-034 start with len=0, and start pulsed during FEED -> no state change, no fifo_rd, pass timing unchanged.
